// File: rtl/signed_bcd_display_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | signed_bcd_display_if : request/result bundle of the signed BCD display  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface signed_bcd_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                      start;
  logic                      signed_mode;
  logic                      ovf;
  logic [WIDTH-1:0]          value;
  logic                      busy;
  logic                      done;
  logic                      neg;
  logic                      ovf_o;
  logic [4*DIGITS-1:0]       bcd;
  logic [7*(DIGITS+1)-1:0]   seg;

  modport master (
    output start, signed_mode, ovf, value,
    input  busy, done, neg, ovf_o, bcd, seg
  );

  modport slave (
    input  start, signed_mode, ovf, value,
    output busy, done, neg, ovf_o, bcd, seg
  );
endinterface
`default_nettype wire

// File: rtl/signed_bcd_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | signed_bcd_display : serial double-dabble sign+magnitude converter that  |
// | drives active-low 7-segment digits from held results.  Rev 1.0           |
// +--------------------------------------------------------------------------+
module signed_bcd_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  signed_bcd_display_if.slave   bus
);

  localparam int          CNT_W  = $clog2(WIDTH + 1);
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_CONV = 2'd1;
  localparam logic [1:0]  S_DONE = 2'd2;

  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [6:0]  SEG_DASH  = 7'b1111110;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [CNT_W-1:0]       cnt;
  logic [WIDTH-1:0]       mag_sr;
  logic [4*DIGITS-1:0]    bcd_sr;
  logic [4*DIGITS-1:0]    bcd_adj;
  logic [4*DIGITS-1:0]    bcd_shift;
  logic                   neg_work;
  logic                   ovf_work;
  logic [4*DIGITS-1:0]    bcd_held;
  logic                   neg_held;
  logic                   ovf_held;
  logic                   accept;
  logic                   last_bit;
  logic                   neg_in;
  logic [WIDTH-1:0]       mag_in;
  logic [7*(DIGITS+1)-1:0] seg_v;
  logic [3:0]             nib;
  logic                   leading;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0001100;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // A request is taken whenever no conversion is running, including the DONE cycle.
  assign accept   = bus.start && (state != S_CONV);
  assign last_bit = (state == S_CONV) && (cnt == CNT_W'(1));
  assign neg_in   = bus.signed_mode & bus.value[WIDTH-1];
  assign mag_in   = neg_in ? ((~bus.value) + ONE) : bus.value;

  // State register
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = accept ? S_CONV : S_IDLE;
      S_CONV:  state_next = last_bit ? S_DONE : S_CONV;
      S_DONE:  state_next = accept ? S_CONV : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = (state == S_CONV);
    bus.done = (state == S_DONE);
  end

  // Add-3 correction on every nibble, then one-bit shift of {bcd_sr, mag_sr}.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[4*DIGITS-2:0], mag_sr[WIDTH-1]};
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt      <= '0;
      mag_sr   <= '0;
      bcd_sr   <= '0;
      neg_work <= 1'b0;
      ovf_work <= 1'b0;
      bcd_held <= '0;
      neg_held <= 1'b0;
      ovf_held <= 1'b0;
    end else if (accept) begin
      cnt      <= CNT_W'(WIDTH);
      mag_sr   <= mag_in;
      bcd_sr   <= '0;
      neg_work <= neg_in;
      ovf_work <= bus.ovf;
    end else if (state == S_CONV) begin
      cnt    <= cnt - CNT_W'(1);
      mag_sr <= {mag_sr[WIDTH-2:0], 1'b0};
      bcd_sr <= bcd_shift;
      // Held results update on the same edge as the final shift.
      if (last_bit) begin
        bcd_held <= bcd_shift;
        neg_held <= neg_work;
        ovf_held <= ovf_work;
      end
    end
  end

  // Display decode: scan from the top digit so leading zeros blank out.
  always_comb begin
    seg_v   = {(DIGITS+1){SEG_BLANK}};
    leading = 1'b1;
    nib     = 4'd0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = bcd_held[4*d +: 4];
      if (nib != 4'd0) begin
        leading = 1'b0;
      end
      if (ovf_held) begin
        seg_v[7*d +: 7] = SEG_DASH;
      end else if (leading && (d != 0)) begin
        seg_v[7*d +: 7] = SEG_BLANK;
      end else begin
        seg_v[7*d +: 7] = seg7(nib);
      end
    end
    seg_v[7*DIGITS +: 7] = (ovf_held || neg_held) ? SEG_DASH : SEG_BLANK;
  end

  assign bus.bcd   = bcd_held;
  assign bus.neg   = neg_held;
  assign bus.ovf_o = ovf_held;
  assign bus.seg   = seg_v;

endmodule
`default_nettype wire

// File: tb/tb_signed_bcd_display.sv
`default_nettype none
// Directed vector bench for signed_bcd_display: table of conversions plus
// hand-written sequences for ignored start, back-to-back start and mid-run reset.
module tb_signed_bcd_display;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DA = 7'b1111110;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;

  typedef struct {
    logic [7:0]  value;
    logic        sm;
    logic        ovf;
    logic [11:0] bcd;
    logic        neg;
    logic [27:0] seg;
  } vec_t;

  logic Clock;
  logic Resetn;
  int   checks;
  int   errors;
  vec_t vecs [10];

  signed_bcd_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  signed_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus.slave)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request; returns #1 after the edge that samples it.
  task automatic start_conv(input logic [7:0] v, input logic sm, input logic ov);
    bus.value       = v;
    bus.signed_mode = sm;
    bus.ovf         = ov;
    bus.start       = 1'b1;
    @(posedge Clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after the sampling edge until done; flags any non-busy cycle.
  task automatic wait_done(output int n, output logic busy_gap);
    n        = 0;
    busy_gap = 1'b0;
    while (!bus.done && n < 20) begin
      if (!bus.busy) busy_gap = 1'b1;
      @(posedge Clock);
      #1;
      n++;
    end
  endtask

  initial begin
    int          n;
    logic        gap;
    logic [27:0] prev_seg;

    checks = 0;
    errors = 0;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.ovf         = 1'b0;
    bus.value       = '0;

    vecs[0] = '{8'h7F, 1'b1, 1'b0, 12'h127, 1'b0, {BL, S1, S2, S7}};
    vecs[1] = '{8'h80, 1'b1, 1'b0, 12'h128, 1'b1, {DA, S1, S2, S8}};
    vecs[2] = '{8'h80, 1'b0, 1'b0, 12'h128, 1'b0, {BL, S1, S2, S8}};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 12'h255, 1'b0, {BL, S2, S5, S5}};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 12'h001, 1'b1, {DA, BL, BL, S1}};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 12'h000, 1'b0, {BL, BL, BL, S0}};
    vecs[6] = '{8'h10, 1'b1, 1'b1, 12'h016, 1'b0, {DA, DA, DA, DA}};
    vecs[7] = '{8'h05, 1'b0, 1'b0, 12'h005, 1'b0, {BL, BL, BL, S5}};
    vecs[8] = '{8'h9C, 1'b1, 1'b0, 12'h100, 1'b1, {DA, S1, S0, S0}};
    vecs[9] = '{8'hF6, 1'b1, 1'b0, 12'h010, 1'b1, {DA, BL, S1, S0}};

    // Reset, with start asserted to show reset dominates.
    Resetn    = 1'b0;
    bus.start = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    bus.start = 1'b0;
    check("reset busy",  32'(bus.busy),  32'd0);
    check("reset done",  32'(bus.done),  32'd0);
    check("reset neg",   32'(bus.neg),   32'd0);
    check("reset ovf_o", 32'(bus.ovf_o), 32'd0);
    check("reset bcd",   32'(bus.bcd),   32'h000);
    check("reset seg",   32'(bus.seg),   32'({BL, BL, BL, S0}));
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
    check("idle after reset busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 10; i++) begin
      start_conv(vecs[i].value, vecs[i].sm, vecs[i].ovf);
      check($sformatf("v%0d busy after start", i), 32'(bus.busy), 32'd1);
      wait_done(n, gap);
      check($sformatf("v%0d latency", i),  32'(n),          32'(WIDTH));
      check($sformatf("v%0d busy gap", i), 32'(gap),        32'd0);
      check($sformatf("v%0d bcd", i),      32'(bus.bcd),    32'(vecs[i].bcd));
      check($sformatf("v%0d neg", i),      32'(bus.neg),    32'(vecs[i].neg));
      check($sformatf("v%0d ovf_o", i),    32'(bus.ovf_o),  32'(vecs[i].ovf));
      check($sformatf("v%0d seg", i),      32'(bus.seg),    32'(vecs[i].seg));
      @(posedge Clock);
      #1;
      check($sformatf("v%0d done pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d seg kept", i),   32'(bus.seg),  32'(vecs[i].seg));
    end

    // Start while busy is ignored; the previous result stays on display.
    prev_seg = bus.seg;
    start_conv(8'h64, 1'b0, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      if (e == 3) begin
        bus.value = 8'h01;
        bus.start = 1'b1;
      end
      @(posedge Clock);
      #1;
      bus.start = 1'b0;
      if (e < 8) begin
        check($sformatf("ign e%0d busy", e), 32'(bus.busy), 32'd1);
        check($sformatf("ign e%0d done", e), 32'(bus.done), 32'd0);
        check($sformatf("ign e%0d held", e), 32'(bus.seg),  32'(prev_seg));
      end else begin
        check("ign done", 32'(bus.done), 32'd1);
        check("ign bcd",  32'(bus.bcd),  32'h100);
        check("ign seg",  32'(bus.seg),  32'({BL, S1, S0, S0}));
      end
    end
    @(posedge Clock);
    #1;
    check("ign single done", 32'(bus.done), 32'd0);

    // Back-to-back: new request presented in the DONE cycle.
    start_conv(8'h2A, 1'b0, 1'b0);
    wait_done(n, gap);
    check("b2b first bcd", 32'(bus.bcd), 32'h042);
    start_conv(8'hC2, 1'b1, 1'b0);
    check("b2b accepted busy", 32'(bus.busy), 32'd1);
    check("b2b held during conv", 32'(bus.bcd), 32'h042);
    wait_done(n, gap);
    check("b2b latency", 32'(n),       32'(WIDTH));
    check("b2b bcd",     32'(bus.bcd), 32'h062);
    check("b2b neg",     32'(bus.neg), 32'd1);
    check("b2b seg",     32'(bus.seg), 32'({DA, BL, S6, S2}));

    // Reset at edge 4 of a conversion aborts it.
    start_conv(8'h55, 1'b0, 1'b0);
    repeat (3) @(posedge Clock);
    #1;
    Resetn = 1'b0;
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort bcd",  32'(bus.bcd),  32'h000);
    check("abort neg",  32'(bus.neg),  32'd0);
    check("abort seg",  32'(bus.seg),  32'({BL, BL, BL, S0}));
    gap = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge Clock);
      #1;
      if (bus.done || bus.busy) gap = 1'b1;
    end
    check("abort no done", 32'(gap), 32'd0);
    start_conv(8'h7F, 1'b1, 1'b0);
    wait_done(n, gap);
    check("post-abort latency", 32'(n),       32'(WIDTH));
    check("post-abort bcd",     32'(bus.bcd), 32'h127);
    check("post-abort seg",     32'(bus.seg), 32'({BL, S1, S2, S7}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
